// File: rtl/wb_interconnect_arb_nx1.sv
// Round-robin N-to-1 Wishbone arbiter. A grant is held for a whole cyc burst.
// An optional watchdog aborts stalled strobes with err.
module wb_interconnect_arb_nx1 #(
  parameter int N_INITIATORS = 2,
  parameter int ADR_WIDTH    = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int TIMEOUT      = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_INITIATORS*ADR_WIDTH-1:0]   t_adr,
  input  logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_w,
  output logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_r,
  input  logic [N_INITIATORS-1:0]             t_cyc,
  output logic [N_INITIATORS-1:0]             t_err,
  input  logic [N_INITIATORS*DAT_WIDTH/8-1:0] t_sel,
  input  logic [N_INITIATORS-1:0]             t_stb,
  output logic [N_INITIATORS-1:0]             t_ack,
  input  logic [N_INITIATORS-1:0]             t_we,
  output logic [ADR_WIDTH-1:0]                i_adr,
  output logic [DAT_WIDTH-1:0]                i_dat_w,
  input  logic [DAT_WIDTH-1:0]                i_dat_r,
  output logic                                i_cyc,
  input  logic                                i_err,
  output logic [DAT_WIDTH/8-1:0]              i_sel,
  output logic                                i_stb,
  input  logic                                i_ack,
  output logic                                i_we
);

  localparam int GW = $clog2(N_INITIATORS);
  localparam int SW = DAT_WIDTH / 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  state_e          state_r, state_nxt_s;
  logic [GW-1:0]   gnt_r, last_r, nxt_gnt_s;
  logic            found_s;
  logic            wd_err_s;

  // Read data is broadcast to every initiator, including during reset.
  assign t_dat_r = {N_INITIATORS{i_dat_r}};

  // Round-robin scan starting just after the most recently granted index.
  always_comb begin
    int idx_v;
    nxt_gnt_s = {GW{1'b0}};
    found_s   = 1'b0;
    idx_v     = 0;
    for (int i = 1; i <= N_INITIATORS; i++) begin
      idx_v = (int'(last_r) + i) % N_INITIATORS;
      if (!found_s && t_cyc[idx_v]) begin
        nxt_gnt_s = GW'(idx_v);
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      gnt_r   <= {GW{1'b0}};
      last_r  <= GW'(N_INITIATORS - 1);
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && found_s) begin
        gnt_r <= nxt_gnt_s;
      end else if (state_r == ST_GRANT && !t_cyc[gnt_r]) begin
        last_r <= gnt_r;
      end else begin
        gnt_r <= gnt_r;
      end
    end
  end

  // Next-state logic: grant on any request, release when the owner drops cyc.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (|t_cyc)        state_nxt_s = ST_GRANT; else state_nxt_s = ST_IDLE;
      ST_GRANT: if (!t_cyc[gnt_r]) state_nxt_s = ST_IDLE;  else state_nxt_s = ST_GRANT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output mux from the registered owner; everything idles at zero otherwise.
  always_comb begin
    i_adr   = {ADR_WIDTH{1'b0}};
    i_dat_w = {DAT_WIDTH{1'b0}};
    i_sel   = {SW{1'b0}};
    i_we    = 1'b0;
    i_cyc   = 1'b0;
    i_stb   = 1'b0;
    t_ack   = {N_INITIATORS{1'b0}};
    t_err   = {N_INITIATORS{1'b0}};
    if (state_r == ST_GRANT && !reset) begin
      i_adr        = t_adr[int'(gnt_r)*ADR_WIDTH +: ADR_WIDTH];
      i_dat_w      = t_dat_w[int'(gnt_r)*DAT_WIDTH +: DAT_WIDTH];
      i_sel        = t_sel[int'(gnt_r)*SW +: SW];
      i_we         = t_we[gnt_r];
      i_cyc        = t_cyc[gnt_r];
      // An aborted strobe is hidden so the target can never ack it late.
      i_stb        = t_stb[gnt_r] & ~wd_err_s;
      t_ack[gnt_r] = i_ack;
      t_err[gnt_r] = i_err | wd_err_s;
    end else begin
      i_cyc = 1'b0;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WDW = $clog2(TIMEOUT + 1);
      logic [WDW-1:0] wd_cnt_r;
      logic           stall_s;
      logic           fire_s;

      // Detect an unanswered strobe and the cycle in which it times out.
      always_comb begin
        stall_s = (state_r == ST_GRANT) && t_stb[gnt_r] && !i_ack && !i_err;
        if (stall_s && (wd_cnt_r == WDW'(TIMEOUT - 1))) begin
          fire_s = 1'b1;
        end else begin
          fire_s = 1'b0;
        end
      end

      // Count consecutive stalled strobe cycles; clear on any answer or abort.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          wd_cnt_r <= {WDW{1'b0}};
        end else if (stall_s && !fire_s) begin
          wd_cnt_r <= wd_cnt_r + {{(WDW-1){1'b0}}, 1'b1};
        end else begin
          wd_cnt_r <= {WDW{1'b0}};
        end
      end

      assign wd_err_s = fire_s;
    end else begin : g_no_wd
      assign wd_err_s = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_interconnect_arb_nx1.sv
// Directed bench for the 2-initiator arbiter with an 8-cycle watchdog.
module tb_wb_interconnect_arb_nx1;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] t_adr, t_dat_w, t_dat_r;
  logic [1:0]  t_cyc, t_err, t_stb, t_ack, t_we;
  logic [7:0]  t_sel;
  logic [31:0] i_adr, i_dat_w, i_dat_r;
  logic        i_cyc, i_err, i_stb, i_ack, i_we;
  logic [3:0]  i_sel;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h1000_0004;

  wb_interconnect_arb_nx1 #(
    .N_INITIATORS(2), .ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r), .t_cyc(t_cyc),
    .t_err(t_err), .t_sel(t_sel), .t_stb(t_stb), .t_ack(t_ack), .t_we(t_we),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r), .i_cyc(i_cyc),
    .i_err(i_err), .i_sel(i_sel), .i_stb(i_stb), .i_ack(i_ack), .i_we(i_we)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    t_adr = {A1, A0}; t_dat_w = 64'h0; t_cyc = 2'b00; t_stb = 2'b00;
    t_we = 2'b00; t_sel = 8'hFF; i_dat_r = 32'h0; i_err = 1'b0; i_ack = 1'b0;

    // Reset state
    #3;
    chk("rst_i_cyc", 64'(i_cyc), 64'd0);
    chk("rst_i_stb", 64'(i_stb), 64'd0);
    chk("rst_t_ack", 64'(t_ack), 64'd0);
    chk("rst_t_err", 64'(t_err), 64'd0);
    tick(); tick();
    reset = 1'b0;

    // Single write from initiator 1
    t_cyc = 2'b10; t_stb = 2'b10; t_we = 2'b10; t_sel = 8'hF0;
    t_dat_w = {32'hDEAD_BEEF, 32'h0};
    #1 chk("wr_latency", 64'(i_cyc), 64'd0);
    tick();
    chk("wr_i_cyc", 64'(i_cyc), 64'd1);
    chk("wr_i_stb", 64'(i_stb), 64'd1);
    chk("wr_i_adr", 64'(i_adr), 64'(A1));
    chk("wr_i_dat", 64'(i_dat_w), 64'h0000_0000_DEAD_BEEF);
    chk("wr_i_we", 64'(i_we), 64'd1);
    chk("wr_i_sel", 64'(i_sel), 64'hF);
    i_ack = 1'b1;
    #1 chk("wr_t_ack", 64'(t_ack), 64'b10);
    tick();
    t_cyc = 2'b00; t_stb = 2'b00; t_we = 2'b00; i_ack = 1'b0; t_sel = 8'hFF;
    #1 chk("wr_rel_mux", 64'(i_cyc), 64'd0);
    chk("wr_rel_ack", 64'(t_ack), 64'd0);
    tick();

    // Four contended bursts: order alternates 0,1,0,1
    t_cyc = 2'b11; t_stb = 2'b11;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("rr_i_cyc", 64'(i_cyc), 64'd1);
      chk("rr_owner_adr", 64'(i_adr), (b % 2 == 0) ? 64'(A0) : 64'(A1));
      i_ack = 1'b1;
      #1 chk("rr_t_ack", 64'(t_ack), (b % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      t_cyc[b % 2] = 1'b0; t_stb[b % 2] = 1'b0; i_ack = 1'b0;
      #1 chk("rr_drop_mux", 64'(i_cyc), 64'd0);
      tick();
      chk("rr_idle_gap", 64'(i_cyc), 64'd0);
      if (b < 3) begin
        t_cyc[b % 2] = 1'b1; t_stb[b % 2] = 1'b1;
      end
    end
    t_cyc = 2'b00; t_stb = 2'b00;
    tick();

    // Initiator 0 holds cyc over three back-to-back reads while 1 waits
    t_cyc = 2'b11; t_stb = 2'b11;
    tick();
    for (int r = 0; r < 3; r++) begin
      i_dat_r = (r == 0) ? 32'h1234_5678 : 32'hA5A5_0000 + 32'(r);
      i_ack = 1'b1;
      #1 chk("rd_t_ack", 64'(t_ack), 64'b01);
      chk("rd_i_cyc", 64'(i_cyc), 64'd1);
      chk("rd_i_adr", 64'(i_adr), 64'(A0));
      chk("rd_dat_r", t_dat_r, {2{i_dat_r}});
      tick();
    end
    i_ack = 1'b0;
    #1 chk("rd_hold_ack", 64'(t_ack), 64'd0);
    t_cyc = 2'b10; t_stb = 2'b10;
    tick();
    chk("rd_rel_idle", 64'(i_cyc), 64'd0);
    tick();
    chk("rd_next_owner", 64'(i_adr), 64'(A1));
    i_ack = 1'b1;
    #1 chk("rd_t_ack1", 64'(t_ack), 64'b10);
    tick();
    i_ack = 1'b0; t_cyc = 2'b00; t_stb = 2'b00;
    tick();

    // Watchdog: initiator 1 strobes, target never answers
    t_cyc = 2'b10; t_stb = 2'b10;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk("wd_t_err", 64'(t_err), (c == 8) ? 64'b10 : 64'b00);
      chk("wd_i_stb", 64'(i_stb), (c == 8) ? 64'd0 : 64'd1);
      chk("wd_i_cyc", 64'(i_cyc), 64'd1);
      tick();
    end
    chk("wd_cleared", 64'(t_err), 64'd0);
    chk("wd_restrobe", 64'(i_stb), 64'd1);
    i_err = 1'b1;
    #1 chk("err_pass", 64'(t_err), 64'b10);
    i_err = 1'b0; t_cyc = 2'b00; t_stb = 2'b00;
    #1 chk("wd_release", 64'(i_cyc), 64'd0);
    tick();

    // Make initiator 0 the last owner, then reset mid-transfer of initiator 1
    t_cyc = 2'b01; t_stb = 2'b01;
    tick();
    t_cyc = 2'b10; t_stb = 2'b10;
    tick();
    tick();
    chk("pre_rst_owner", 64'(i_adr), 64'(A1));
    i_ack = 1'b1; i_dat_r = 32'h5A5A_5A5A;
    #1 chk("pre_rst_ack", 64'(t_ack), 64'b10);
    reset = 1'b1;
    #1 chk("mid_rst_i_cyc", 64'(i_cyc), 64'd0);
    chk("mid_rst_i_stb", 64'(i_stb), 64'd0);
    chk("mid_rst_t_ack", 64'(t_ack), 64'd0);
    chk("mid_rst_t_err", 64'(t_err), 64'd0);
    chk("mid_rst_dat_r", t_dat_r, 64'h5A5A_5A5A_5A5A_5A5A);
    t_cyc = 2'b11; t_stb = 2'b11;
    tick();
    reset = 1'b0; i_ack = 1'b0;
    #1 chk("post_rst_idle", 64'(i_cyc), 64'd0);
    tick();
    chk("post_rst_prio", 64'(i_adr), 64'(A0));
    t_cyc = 2'b00; t_stb = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
